// File: rtl/ysyx_22040127_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ysyx_22040127_fetch_pkg;

  localparam int IF_TO_ID_WIDTH = 64;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

  // REQ issues a fetch, WAIT expects the answer, HOLD offers it to decode,
  // DROP swallows the answer of a request that a redirect made stale.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetchState_t;

  // Payload handed to decode: instruction in the upper word, its PC below.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ifToId_t;

  // Forces an address onto a word boundary; low bits are simply dropped.
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22040127_fetch_if.sv
// Bundle of the imem request/response, decode handshake and redirect wires.
interface ysyx_22040127_fetch_if;
  import ysyx_22040127_fetch_pkg::*;

  logic                      imem_req_valid;
  logic                      imem_req_ready;
  logic [31:0]               imem_addr;
  logic                      imem_rsp_valid;
  logic [31:0]               imem_rsp_data;
  logic                      if_to_id_valid;
  logic                      id_allowin;
  logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus;
  logic                      br_taken;
  logic [31:0]               br_target;

  // The fetch stage drives requests and the decode offer.
  modport master (
    output imem_req_valid, imem_addr, if_to_id_valid, if_to_id_bus,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_allowin,
           br_taken, br_target
  );

  // Memory, decode and branch unit sit on the other side.
  modport slave (
    input  imem_req_valid, imem_addr, if_to_id_valid, if_to_id_bus,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_allowin,
           br_taken, br_target
  );

endinterface

// File: rtl/ysyx_22040127_fetch.sv
// Instruction-fetch stage: one outstanding imem request, a one-entry
// instruction buffer, and redirect handling that squashes wrong-path work.
module ysyx_22040127_fetch
  import ysyx_22040127_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input logic                   clk,
  input logic                   rst,
  ysyx_22040127_fetch_if.master bus
);

  fetchState_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetchPc_q, fetchPc_d;
  logic [31:0] inst_q, inst_d;

  logic        reqValid;
  logic        idValid;
  logic [31:0] reqAddr;
  ifToId_t     idPayload;

  // Output decode: a redirect combinationally suppresses both the request
  // and the decode offer, and reset keeps every valid and the bus at zero.
  always_comb begin
    reqAddr             = alignWord(pc_q);
    reqValid            = !rst && (state_q == ST_REQ)  && !bus.br_taken;
    idValid             = !rst && (state_q == ST_HOLD) && !bus.br_taken;
    idPayload.inst      = inst_q;
    idPayload.pc        = fetchPc_q;
    bus.imem_req_valid  = reqValid;
    bus.imem_addr       = reqAddr;
    bus.if_to_id_valid  = idValid;
    bus.if_to_id_bus    = rst ? '0 : idPayload;
  end

  // Next-state logic: the redirect wins over every other transition, and a
  // stray response outside WAIT/DROP never moves the machine.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fetchPc_d = fetchPc_q;
    inst_d    = inst_q;

    if (bus.br_taken) begin
      pc_d = alignWord(bus.br_target);
      unique case (state_q)
        ST_REQ:  state_d = ST_REQ;
        ST_WAIT: state_d = bus.imem_rsp_valid ? ST_REQ : ST_DROP;
        ST_HOLD: state_d = ST_REQ;
        ST_DROP: state_d = bus.imem_rsp_valid ? ST_REQ : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (reqValid && bus.imem_req_ready) begin
            fetchPc_d = reqAddr;
            state_d   = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            inst_d  = bus.imem_rsp_data;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (idValid && bus.id_allowin) begin
            pc_d    = fetchPc_q + PC_STEP;
            state_d = ST_REQ;
          end
        end
        ST_DROP: begin
          if (bus.imem_rsp_valid) begin
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  // State registers; reset abandons any request still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      fetchPc_q <= '0;
      inst_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fetchPc_q <= fetchPc_d;
      inst_q    <= inst_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040127_fetch.sv
// Scoreboard bench for the fetch stage: directed cycle-by-cycle stimulus,
// a simple latency-programmable memory, and a monitor popping expectations.
module tb_ysyx_22040127_fetch;
  import ysyx_22040127_fetch_pkg::*;

  logic clk;
  logic rst;

  ysyx_22040127_fetch_if fetchBus();

  ysyx_22040127_fetch #(
    .RESET_PC(32'h8000_0000),
    .PC_STEP (32'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(fetchBus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] expAddrQ[$];
  logic [63:0] expBusQ[$];

  int          memLatency = 1;
  logic [31:0] memWord    = 32'h0000_0013;

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [63:0] actual);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got %h, expected nothing", name, actual);
  endtask

  task automatic applyStimulus(input logic ready, input logic allowin, input logic br, input logic [31:0] target);
    fetchBus.imem_req_ready = ready;
    fetchBus.id_allowin     = allowin;
    fetchBus.br_taken       = br;
    fetchBus.br_target      = target;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: answers an accepted request memLatency cycles later.
  initial begin
    int   pending;
    logic acceptNow;
    pending                 = 0;
    fetchBus.imem_rsp_valid = 1'b0;
    fetchBus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      acceptNow = fetchBus.imem_req_valid && fetchBus.imem_req_ready;
      @(posedge clk);
      #1;
      fetchBus.imem_rsp_valid = 1'b0;
      if (acceptNow) pending = memLatency;
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          fetchBus.imem_rsp_valid = 1'b1;
          fetchBus.imem_rsp_data  = memWord;
        end
      end
    end
  end

  // Monitor: every accepted request and every decode handoff must match the
  // next queued expectation; anything unexpected is a miscompare.
  initial begin
    logic [31:0] expAddr;
    logic [63:0] expBus;
    forever begin
      @(negedge clk);
      if (fetchBus.imem_req_valid && fetchBus.imem_req_ready) begin
        if (expAddrQ.size() == 0) begin
          reportUnexpected("unexpectedReq", 64'(fetchBus.imem_addr));
        end else begin
          expAddr = expAddrQ.pop_front();
          checkOutput("reqAddr", 64'(fetchBus.imem_addr), 64'(expAddr));
        end
      end
      if (fetchBus.if_to_id_valid && fetchBus.id_allowin) begin
        if (expBusQ.size() == 0) begin
          reportUnexpected("unexpectedHandoff", fetchBus.if_to_id_bus);
        end else begin
          expBus = expBusQ.pop_front();
          checkOutput("handoffBus", fetchBus.if_to_id_bus, expBus);
        end
      end
    end
  end

  // Directed sequence; cycle numbers count from reset release.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rstReqValid", 64'(fetchBus.imem_req_valid), 64'd0);
    checkOutput("rstIdValid", 64'(fetchBus.if_to_id_valid), 64'd0);
    checkOutput("rstBus", fetchBus.if_to_id_bus, 64'd0);

    // Zero-wait streaming: one handoff every third cycle.
    expAddrQ.push_back(32'h8000_0000);
    expAddrQ.push_back(32'h8000_0004);
    expAddrQ.push_back(32'h8000_0008);
    expAddrQ.push_back(32'h8000_000C);
    expBusQ.push_back({32'h0000_0013, 32'h8000_0000});
    expBusQ.push_back({32'h0000_0013, 32'h8000_0004});
    expBusQ.push_back({32'h0000_0013, 32'h8000_0008});
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checkOutput("streamIdValid", 64'(fetchBus.if_to_id_valid), 64'(i % 3 == 2));
      checkOutput("streamReqValid", 64'(fetchBus.imem_req_valid), 64'(i % 3 == 0));
      tick();
    end

    // Cycle 9: decode stalls for five HOLD cycles.
    memWord = 32'h0010_0093;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    expBusQ.push_back({32'h0010_0093, 32'h8000_000C});
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stallIdValid", 64'(fetchBus.if_to_id_valid), 64'd1);
      checkOutput("stallBus", fetchBus.if_to_id_bus, {32'h0010_0093, 32'h8000_000C});
      checkOutput("stallNoReq", 64'(fetchBus.imem_req_valid), 64'd0);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("stallRelease", 64'(fetchBus.if_to_id_valid), 64'd1);
    tick();

    // Cycle 17: redirect during WAIT, stale response two cycles later.
    memLatency = 3;
    memWord    = 32'hDEAD_BEEF;
    expAddrQ.push_back(32'h8000_0010);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h8000_0100);
    @(negedge clk);
    checkOutput("brWaitIdValid", 64'(fetchBus.if_to_id_valid), 64'd0);
    checkOutput("brWaitReqValid", 64'(fetchBus.imem_req_valid), 64'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("dropIdValid", 64'(fetchBus.if_to_id_valid), 64'd0);
      checkOutput("dropReqValid", 64'(fetchBus.imem_req_valid), 64'd0);
      tick();
    end
    memLatency = 1;
    memWord    = 32'h0020_0113;
    expAddrQ.push_back(32'h8000_0100);
    expBusQ.push_back({32'h0020_0113, 32'h8000_0100});
    @(negedge clk);
    checkOutput("redirectAddr", 64'(fetchBus.imem_addr), 64'h8000_0100);
    checkOutput("redirectReqValid", 64'(fetchBus.imem_req_valid), 64'd1);
    tick();
    tick();
    @(negedge clk);
    checkOutput("redirectHandoff", 64'(fetchBus.if_to_id_valid), 64'd1);
    tick();

    // Cycle 24: redirect while HOLD with decode ready; buffer is discarded.
    memWord = 32'hBADC_0DE5;
    expAddrQ.push_back(32'h8000_0104);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h8000_0300);
    @(negedge clk);
    checkOutput("brHoldIdValid", 64'(fetchBus.if_to_id_valid), 64'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    memWord = 32'h0030_0193;
    expAddrQ.push_back(32'h8000_0300);
    expBusQ.push_back({32'h0030_0193, 32'h8000_0300});
    tick();
    tick();
    tick();

    // Cycle 30: redirect in REQ to a misaligned target.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h8000_0203);
    @(negedge clk);
    checkOutput("brReqNoReq", 64'(fetchBus.imem_req_valid), 64'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    memLatency = 3;
    memWord    = 32'hFEED_FACE;
    expAddrQ.push_back(32'h8000_0200);
    @(negedge clk);
    checkOutput("alignedAddr", 64'(fetchBus.imem_addr), 64'h8000_0200);
    tick();

    // Cycle 32: reset while WAIT; the late response lands in REQ.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("midRstReqValid", 64'(fetchBus.imem_req_valid), 64'd0);
    checkOutput("midRstBus", fetchBus.if_to_id_bus, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstAddr", 64'(fetchBus.imem_addr), 64'h8000_0000);
    checkOutput("postRstReqValid", 64'(fetchBus.imem_req_valid), 64'd1);
    tick();
    @(negedge clk);
    checkOutput("lateRspIdValid", 64'(fetchBus.if_to_id_valid), 64'd0);
    checkOutput("lateRspReqValid", 64'(fetchBus.imem_req_valid), 64'd1);
    tick();
    memLatency = 1;
    memWord    = 32'h0040_0213;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    expAddrQ.push_back(32'h8000_0000);
    expBusQ.push_back({32'h0040_0213, 32'h8000_0000});
    tick();
    @(negedge clk);
    checkOutput("postRstWaitIdValid", 64'(fetchBus.if_to_id_valid), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("postRstHandoff", 64'(fetchBus.if_to_id_valid), 64'd1);
    tick();

    // Cycle 38: PC wrap from the top of the address space.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    @(negedge clk);
    checkOutput("wrapBrNoReq", 64'(fetchBus.imem_req_valid), 64'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    memWord = 32'h0050_0293;
    expAddrQ.push_back(32'hFFFF_FFFC);
    expBusQ.push_back({32'h0050_0293, 32'hFFFF_FFFC});
    expAddrQ.push_back(32'h0000_0000);
    expBusQ.push_back({32'h0060_0313, 32'h0000_0000});
    tick();
    tick();
    tick();
    memWord = 32'h0060_0313;
    @(negedge clk);
    checkOutput("wrapAddr", 64'(fetchBus.imem_addr), 64'h0);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) tick();

    @(negedge clk);
    checkOutput("addrQueueDrained", 64'(expAddrQ.size()), 64'd0);
    checkOutput("busQueueDrained", 64'(expBusQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_22040127_fetch.md
Name: ysyx_22040127_fetch

Overview:
Instruction-fetch stage directly upstream of decode. It holds the architectural fetch PC and issues one word request at a time to the instruction memory. It buffers the returned instruction and offers {instruction, pc} to decode over the valid/allowin handshake. It accepts the branch/jump redirect that decode resolves, and squashes the wrong-path request or instruction.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  32  fetch address, word aligned
imem_rsp_valid  input  1  response data valid
imem_rsp_data  input  32  fetched instruction
if_to_id_valid  output  1  instruction offered to decode
id_allowin  input  1  decode can accept this cycle
if_to_id_bus  output  `IF_TO_ID_WIDTH (64)  {instruction[63:32], pc[31:0]}
br_taken  input  1  redirect; asserted only while decode holds a valid taken branch or jump
br_target  input  32  redirect target PC

Behaviour:
- Reset (rst=1 at posedge):
  - pc <= RESET_PC; state <= REQ; buffer cleared.
  - imem_req_valid=0, if_to_id_valid=0, if_to_id_bus=0 while rst is high.
  - Reset mid-transaction abandons any outstanding request. Memory responses are ignored until a new request is accepted.
- State machine. There is at most one outstanding request.
  - REQ:
    - imem_req_valid = !br_taken; imem_addr = {pc[31:2], 2'b00}.
    - imem_req_valid && imem_req_ready -> WAIT; the issued PC is latched as fetch_pc.
  - WAIT:
    - imem_rsp_valid -> latch imem_rsp_data into buffer -> HOLD.
  - HOLD:
    - if_to_id_valid = !br_taken; if_to_id_bus = {buffer, fetch_pc}.
    - if_to_id_valid && id_allowin -> pc <= fetch_pc + PC_STEP -> REQ.
    - Otherwise stay in HOLD; bus contents stay stable.
  - DROP:
    - Discard the next imem_rsp_valid -> REQ.
- Latency:
  - Request accepted at cycle t, response at t+k -> if_to_id_valid at t+k+1.
  - Handoff at cycle h -> next request issued at h+1.
  - Peak throughput is 1 instruction per 3 cycles with a zero-wait memory.
- Redirect (br_taken=1, any state) has priority over all other transitions:
  - The instruction in IF is the wrong path. if_to_id_valid is forced to 0 that cycle, so no transfer occurs even if id_allowin=1.
  - pc <= {br_target[31:2], 2'b00}. Bits [1:0] are ignored; misalignment is not flagged.
  - REQ: no request is issued that cycle; stay in REQ.
  - WAIT without imem_rsp_valid -> DROP.
  - WAIT with imem_rsp_valid the same cycle -> response discarded -> REQ.
  - HOLD: buffer discarded -> REQ.
  - DROP: pc updated; stay in DROP until the response arrives.
- imem_rsp_valid in REQ or HOLD is ignored; this is a protocol error and must not change state.
- PC arithmetic is 32-bit modular; 0xFFFF_FFFC + 4 wraps to 0.
- No combinational path from imem_rsp_* to if_to_id_*. The only combinational paths to outputs are br_taken -> if_to_id_valid and br_taken -> imem_req_valid.

Decomposition:
- mycpu.h holds `IF_TO_ID_WIDTH (64), `RESET_PC and the 2-bit state encodings: REQ=0, WAIT=1, HOLD=2, DROP=3.
- Single module; no sub-module is warranted. The response buffer and FSM are small enough to keep inline.

Test Plan:
- Reset release, zero-wait memory returning 0x00000013 at every address, id_allowin=1 -> requests 0x80000000, 0x80000004, 0x80000008; bus = {0x00000013, 0x80000000} one cycle after the first response; one handoff every 3 cycles.
- id_allowin=0 for 5 cycles while in HOLD -> if_to_id_valid held at 1; bus stable; no new imem request; handoff on the first cycle allowin=1.
- br_taken with br_target=0x80000100 while in WAIT, response 2 cycles later -> that response is dropped; next request addr=0x80000100; nothing delivered to decode in between.
- br_taken in HOLD with id_allowin=1 -> if_to_id_valid=0 that cycle; next request addr=target; the old buffered instruction is never delivered.
- br_taken with br_target=0x80000203 in REQ with imem_req_ready=1 -> no request that cycle; next cycle imem_addr=0x80000200.
- rst asserted while in WAIT, late response arrives after reset -> response ignored; first request addr=0x80000000.
